// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST command constants, word layout and sequencer state encoding.
package bist_pkg;

  localparam int CMD_W  = 8;
  localparam int DATA_W = 8;
  localparam int WORD_W = CMD_W + DATA_W;
  localparam int TMR_W  = 16;

  // Also decoded by the BIST engine, so both sides must agree on these values.
  localparam logic [CMD_W-1:0] BIST_CMD_NOP = 8'h00;
  localparam logic [CMD_W-1:0] BIST_CMD_CLR = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    CLEAR
  } state_t;

  function automatic logic [CMD_W-1:0] word_cmd(input logic [WORD_W-1:0] word);
    return word[WORD_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/bist_cmd_fifo.sv
// rtl/bist_cmd_fifo.sv - synchronous command FIFO with occupancy output; head is read combinationally.
module bist_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two; level tells full from empty.
  always_ff @(posedge clk) begin
    if (res) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/bist_cmd_sequencer.sv
// rtl/bist_cmd_sequencer.sv - queues JTAG command words and sequences them into the BIST buffer/engine.
module bist_cmd_sequencer
  import bist_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter int               TIMEOUT    = 255,
  parameter logic [CMD_W-1:0] CMD_NOP    = BIST_CMD_NOP,
  parameter logic [CMD_W-1:0] CMD_CLR    = BIST_CMD_CLR
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          cmd_valid,
  input  logic [WORD_W-1:0]             cmd_word,
  output logic                          cmd_ready,
  input  logic                          err_clr,
  output logic                          buf_write_en,
  output logic                          buf_res,
  output logic [WORD_W-1:0]             buf_in,
  output logic                          exec_start,
  input  logic                          exec_done,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [TMR_W-1:0] TIMEOUT_VAL = TMR_W'(TIMEOUT);

  state_t             state;
  state_t             state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_nxt;
  logic [WORD_W-1:0]  head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               err_set;

  bist_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (cmd_valid),
    .wdata (cmd_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (word_cmd(head) == CMD_NOP)      state_nxt = IDLE;
          else if (word_cmd(head) == CMD_CLR) state_nxt = CLEAR;
          else                                state_nxt = LOAD;
        end
      end
      LOAD:  state_nxt = START;
      START: begin
        timer_nxt = TIMEOUT_VAL;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Completion on the expiry cycle still counts as success.
        if (exec_done) begin
          state_nxt = IDLE;
        end else if (timer == '0) begin
          err_set   = 1'b1;
          state_nxt = CLEAR;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each lands in the cycle its state is occupied.
  always_ff @(posedge clk) begin
    if (res) begin
      state        <= IDLE;
      timer        <= '0;
      buf_write_en <= 1'b0;
      exec_start   <= 1'b0;
      buf_res      <= 1'b0;
      buf_in       <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      buf_write_en <= (state_nxt == LOAD);
      exec_start   <= (state_nxt == START);
      buf_res      <= (state_nxt == CLEAR);
      if (pop && (state_nxt == LOAD)) buf_in <= head;
      if (err_set)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule
